sata_fis_tx_mux: RTL and testbench
==================================

SATA_FIS_TX_MUX -- requirements
Module: sata_fis_tx_mux

Interface
REQ-001 SHALL have parameter MAX_DATA_DWORDS, default 2048, giving the maximum payload dwords per transmitted Data FIS (legal range 1..2048).
REQ-002 SHALL have port clk  input  1  clock; all sequential logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reg_dat/reg_val/reg_eop/reg_err  input  32/1/1/1  complete Register H2D frames (header included); reg_rdy  output  1.
REQ-005 SHALL have ports data_dat/data_val/data_eop/data_err  input  32/1/1/1  Data FIS payload stream without header, of any length; data_rdy  output  1.
REQ-006 SHALL have ports default_dat/default_val/default_eop/default_err  input  32/1/1/1  complete frames of any other type; default_rdy  output  1.
REQ-007 SHALL have ports tx_dat/tx_val/tx_eop/tx_err  output  32/1/1/1  merged transmit frame stream; tx_rdy  input  1.

Function
REQ-008 SHALL complete a word transfer on any stream only in a cycle where val and rdy are both 1; stream semantics are valid/ready with eop marking the last word of a frame.
REQ-009 SHALL implement FSM states IDLE, REG, DEFAULT, DATA_HDR, DATA.
REQ-010 In IDLE: tx_val=0, tx_dat=0, tx_eop=0, tx_err=0, all source rdy=0.
REQ-011 In IDLE, next state SHALL be chosen by fixed priority: reg_val -> REG, else default_val -> DEFAULT, else data_val -> DATA_HDR, else IDLE; an IDLE cycle SHALL always be spent between frames (1-cycle arbitration bubble).
REQ-012 In REG: tx_dat/val/eop/err = reg_dat/val/eop/err, reg_rdy = tx_rdy, other rdy = 0; transfer with reg_eop=1 -> IDLE.
REQ-013 In DEFAULT: same as REG with the default_* stream.
REQ-014 In DATA_HDR: tx_dat=32'h0000_0046, tx_val=1, tx_eop=0, tx_err=0, all source rdy=0; on tx_rdy=1 -> DATA, payload counter cleared to 0.
REQ-015 Header word SHALL be held stable while tx_rdy=0.
REQ-016 In DATA: tx_dat/val/err = data_dat/val/err, data_rdy = tx_rdy, other rdy = 0, tx_eop = data_eop OR (count == MAX_DATA_DWORDS-1).
REQ-017 Payload counter SHALL be 12 bits, increment by 1 on each DATA transfer, never exceed MAX_DATA_DWORDS-1.
REQ-018 Transfer in DATA with tx_eop=1 -> IDLE.
REQ-019 When the limit forces tx_eop while data_eop=0, the remaining source payload SHALL be sent as further Data FISes, each with its own header, after normal re-arbitration (higher-priority frames may interleave).
REQ-020 When data_eop=1 coincides with the limit word, exactly one eop SHALL be emitted and no empty follow-on FIS generated.
REQ-021 A frame in progress SHALL never be preempted; source val changes on other inputs SHALL be ignored until return to IDLE.
REQ-022 Source err SHALL pass through unmodified on its word; err SHALL NOT terminate a frame (only eop does).
REQ-023 tx_* outputs and source rdy SHALL be combinational functions of state, counter and inputs (zero added latency outside DATA_HDR/IDLE).

Reset
REQ-024 Reset assertion SHALL asynchronously force state IDLE and counter 0, giving tx_val=0, tx_dat=0, tx_eop=0, tx_err=0, reg_rdy=data_rdy=default_rdy=0.
REQ-025 Reset mid-frame SHALL abandon the frame; no eop is emitted for it, and after release arbitration restarts from IDLE.

Verification
REQ-026 Reg frame 5 dwords, tx_rdy=1 -> 1 IDLE cycle, then 5 tx words equal to reg_dat, tx_eop only on 5th, reg_rdy high exactly 5 cycles.
REQ-027 Data payload 3 dwords -> tx words 0x00000046, p0, p1, p2; tx_eop on p2 only; data_rdy low during header.
REQ-028 Data payload 4100 dwords with MAX_DATA_DWORDS=2048 -> three FISes of 1+2048, 1+2048, 1+4 words, eop on payload words 2048, 4096, 4100, each header 0x46.
REQ-029 reg_val and data_val both 1 in IDLE -> full reg frame first, then IDLE, then data header; also reg_val raised mid-DATA is not served until data FIS eop.
REQ-030 tx_rdy toggling 0/1 in DATA_HDR and DATA -> tx_dat held stable while tx_rdy=0, no word lost or duplicated, counter advances only on transfers.
REQ-031 Reset pulsed after 10 data payload words -> tx_val=0 immediately, next data_val in IDLE produces a fresh 0x46 header.

Source files
------------

// File: rtl/sata_fis_tx_mux.sv
// Transmit-side FIS multiplexer: merges Register H2D, Data payload and other
// frames onto one link stream, inserting Data FIS headers and splitting long payloads.
module sata_fis_tx_mux #(
    parameter int MAX_DATA_DWORDS = 2048
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] reg_dat,
    input  logic        reg_val,
    input  logic        reg_eop,
    input  logic        reg_err,
    output logic        reg_rdy,

    input  logic [31:0] data_dat,
    input  logic        data_val,
    input  logic        data_eop,
    input  logic        data_err,
    output logic        data_rdy,

    input  logic [31:0] default_dat,
    input  logic        default_val,
    input  logic        default_eop,
    input  logic        default_err,
    output logic        default_rdy,

    output logic [31:0] tx_dat,
    output logic        tx_val,
    output logic        tx_eop,
    output logic        tx_err,
    input  logic        tx_rdy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REG      = 3'd1;
    localparam logic [2:0] S_DEFAULT  = 3'd2;
    localparam logic [2:0] S_DATA_HDR = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;

    localparam logic [31:0] DATA_FIS_HDR = 32'h0000_0046;
    localparam logic [11:0] CNT_LAST     = 12'(MAX_DATA_DWORDS - 1);

    logic [2:0]  state, state_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic        data_last;

    // The limit word closes the FIS even if the source payload continues.
    assign data_last = data_eop | (cnt == CNT_LAST);

    always_comb begin
        tx_dat      = '0;
        tx_val      = 1'b0;
        tx_eop      = 1'b0;
        tx_err      = 1'b0;
        reg_rdy     = 1'b0;
        data_rdy    = 1'b0;
        default_rdy = 1'b0;
        case (state)
            S_REG: begin
                tx_dat  = reg_dat;
                tx_val  = reg_val;
                tx_eop  = reg_eop;
                tx_err  = reg_err;
                reg_rdy = tx_rdy;
            end
            S_DEFAULT: begin
                tx_dat      = default_dat;
                tx_val      = default_val;
                tx_eop      = default_eop;
                tx_err      = default_err;
                default_rdy = tx_rdy;
            end
            S_DATA_HDR: begin
                tx_dat = DATA_FIS_HDR;
                tx_val = 1'b1;
            end
            S_DATA: begin
                tx_dat   = data_dat;
                tx_val   = data_val;
                tx_eop   = data_last;
                tx_err   = data_err;
                data_rdy = tx_rdy;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (reg_val)
                    state_nxt = S_REG;
                else if (default_val)
                    state_nxt = S_DEFAULT;
                else if (data_val)
                    state_nxt = S_DATA_HDR;
            end
            S_REG: begin
                if (reg_val && tx_rdy && reg_eop)
                    state_nxt = S_IDLE;
            end
            S_DEFAULT: begin
                if (default_val && tx_rdy && default_eop)
                    state_nxt = S_IDLE;
            end
            S_DATA_HDR: begin
                if (tx_rdy) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (data_val && tx_rdy) begin
                    if (data_last)
                        state_nxt = S_IDLE;
                    else
                        cnt_nxt = cnt + 12'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sata_fis_tx_mux.sv
// Bench for sata_fis_tx_mux: queue-driven sources, expected link stream built
// from frame/payload splitting rules, compared word by word.
module tb_sata_fis_tx_mux;

    localparam int MAXD = 2048;

    typedef struct packed {
        logic [31:0] dat;
        logic        eop;
        logic        err;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] reg_dat = '0, data_dat = '0, default_dat = '0;
    logic        reg_val = 1'b0, reg_eop = 1'b0, reg_err = 1'b0;
    logic        data_val = 1'b0, data_eop = 1'b0, data_err = 1'b0;
    logic        default_val = 1'b0, default_eop = 1'b0, default_err = 1'b0;
    logic        reg_rdy, data_rdy, default_rdy;
    logic [31:0] tx_dat;
    logic        tx_val, tx_eop, tx_err;
    logic        tx_rdy = 1'b0;

    sata_fis_tx_mux #(.MAX_DATA_DWORDS(MAXD)) dut (
        .clk(clk), .reset(reset),
        .reg_dat(reg_dat), .reg_val(reg_val), .reg_eop(reg_eop), .reg_err(reg_err), .reg_rdy(reg_rdy),
        .data_dat(data_dat), .data_val(data_val), .data_eop(data_eop), .data_err(data_err), .data_rdy(data_rdy),
        .default_dat(default_dat), .default_val(default_val), .default_eop(default_eop),
        .default_err(default_err), .default_rdy(default_rdy),
        .tx_dat(tx_dat), .tx_val(tx_val), .tx_eop(tx_eop), .tx_err(tx_err), .tx_rdy(tx_rdy)
    );

    always #5 clk = ~clk;

    word_t rq[$], fq[$], dq[$], expq[$], gotq[$];
    int    tests = 0, fails = 0;
    bit    f_reg, f_def, f_dat, rnd_rdy, prev_stall;
    logic [31:0] prev_dat;
    int    reg_rdy_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic apply_inputs();
        reg_val = rq.size() != 0;
        {reg_dat, reg_eop, reg_err} = reg_val ? rq[0] : '0;
        default_val = fq.size() != 0;
        {default_dat, default_eop, default_err} = default_val ? fq[0] : '0;
        data_val = dq.size() != 0;
        {data_dat, data_eop, data_err} = data_val ? dq[0] : '0;
    endtask

    // Inputs change on the falling edge; handshakes are sampled 1 ns later and
    // take effect at the following rising edge.
    task automatic step();
        word_t w;
        @(negedge clk);
        if (f_reg) void'(rq.pop_front());
        if (f_def) void'(fq.pop_front());
        if (f_dat) void'(dq.pop_front());
        apply_inputs();
        tx_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prev_stall) begin
            chk("hold_val", 64'(tx_val), 64'd1);
            chk("hold_dat", 64'(tx_dat), 64'(prev_dat));
        end
        if (!tx_val) chk("idle_dat", 64'(tx_dat), 64'd0);
        f_reg = reg_val && reg_rdy;
        f_def = default_val && default_rdy;
        f_dat = data_val && data_rdy;
        if (reg_rdy) reg_rdy_cnt++;
        if (tx_val && tx_rdy) begin
            w.dat = tx_dat; w.eop = tx_eop; w.err = tx_err;
            gotq.push_back(w);
        end
        prev_stall = tx_val && !tx_rdy;
        prev_dat   = tx_dat;
    endtask

    task automatic add_frame(input int src, input int len);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.dat = $urandom;
            w.err = ($urandom_range(0, 7) == 0);
            w.eop = (i == len - 1);
            if (src == 0) rq.push_back(w); else fq.push_back(w);
            expq.push_back(w);
        end
    endtask

    // Expected link view: a header before every MAXD-word chunk, eop at chunk end.
    task automatic add_data(input int len);
        word_t w, e, h;
        h.dat = 32'h0000_0046; h.eop = 1'b0; h.err = 1'b0;
        for (int i = 0; i < len; i++) begin
            w.dat = $urandom;
            w.err = ($urandom_range(0, 7) == 0);
            w.eop = (i == len - 1);
            dq.push_back(w);
            if (i % MAXD == 0) expq.push_back(h);
            e = w;
            e.eop = w.eop || (i % MAXD == MAXD - 1);
            expq.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rq.size() != 0 || fq.size() != 0 || dq.size() != 0 || gotq.size() < expq.size())
               && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n < budget), 64'd1);
        step();
        step();
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_nwords"}, 64'(gotq.size()), 64'(expq.size()));
        n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(gotq[i]), 64'(expq[i]));
        gotq.delete();
        expq.delete();
    endtask

    initial begin
        int n;
        rnd_rdy = 1'b0; f_reg = 0; f_def = 0; f_dat = 0; prev_stall = 0; prev_dat = '0;
        reg_rdy_cnt = 0;

        // reset state
        reg_val = 1'b1; data_val = 1'b1; default_val = 1'b1; tx_rdy = 1'b1;
        @(negedge clk); #1;
        chk("rst_tx_val", 64'(tx_val), 64'd0);
        chk("rst_tx_dat", 64'(tx_dat), 64'd0);
        chk("rst_tx_eop", 64'(tx_eop), 64'd0);
        chk("rst_tx_err", 64'(tx_err), 64'd0);
        chk("rst_rdys", 64'({reg_rdy, data_rdy, default_rdy}), 64'd0);
        apply_inputs();
        @(negedge clk);
        reset = 1'b0;

        // 5-dword register frame, always ready
        add_frame(0, 5);
        reg_rdy_cnt = 0;
        step();
        chk("reg_bubble_val", 64'(tx_val), 64'd0);
        chk("reg_bubble_rdy", 64'(reg_rdy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("reg_val%0d", i), 64'(tx_val), 64'd1);
            chk($sformatf("reg_eop%0d", i), 64'(tx_eop), 64'(i == 4));
        end
        step();
        chk("reg_after_val", 64'(tx_val), 64'd0);
        drain(50);
        chk("reg_rdy_cycles", 64'(reg_rdy_cnt), 64'd5);
        compare("reg5");

        // 3-dword payload: header then payload, data_rdy low during header
        add_data(3);
        step();
        chk("hdr_bubble", 64'(tx_val), 64'd0);
        step();
        chk("hdr_dat", 64'(tx_dat), 64'h46);
        chk("hdr_data_rdy", 64'(data_rdy), 64'd0);
        chk("hdr_eop", 64'(tx_eop), 64'd0);
        drain(50);
        compare("data3");

        // reg and data pending together: reg wins
        add_frame(0, 4);
        add_data(3);
        drain(100);
        compare("prio");

        // reg raised mid-DATA waits for the data FIS eop
        add_data(6);
        n = 0;
        while (gotq.size() < 4 && n < 100) begin step(); n++; end
        chk("mid_timeout", 64'(n < 100), 64'd1);
        add_frame(0, 3);
        drain(100);
        compare("nopreempt");

        // randomized mixes with back-pressure
        for (int it = 0; it < 8; it++) begin
            rnd_rdy = 1'($urandom_range(0, 1));
            for (int k = $urandom_range(0, 3); k > 0; k--) add_frame(0, $urandom_range(1, 6));
            for (int k = $urandom_range(0, 3); k > 0; k--) add_frame(2, $urandom_range(1, 6));
            for (int k = $urandom_range(0, 2); k > 0; k--) add_data($urandom_range(1, 8));
            drain(2000);
            compare($sformatf("rand%0d", it));
        end

        // limit boundaries
        rnd_rdy = 1'b0;
        add_data(MAXD);
        drain(3000);
        compare("len2048");
        rnd_rdy = 1'b1;
        add_data(MAXD + 1);
        drain(10000);
        compare("len2049");
        add_data(4100);
        drain(20000);
        compare("len4100");

        // reset after 10 payload words
        rnd_rdy = 1'b0;
        add_data(20);
        n = 0;
        while (gotq.size() < 11 && n < 100) begin step(); n++; end
        chk("rst_mid_timeout", 64'(n < 100), 64'd1);
        for (int i = 0; i < gotq.size(); i++) chk($sformatf("pre_rst_eop%0d", i), 64'(gotq[i].eop), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_val", 64'(tx_val), 64'd0);
        chk("rst_mid_rdy", 64'(data_rdy), 64'd0);
        rq.delete(); fq.delete(); dq.delete(); gotq.delete(); expq.delete();
        f_reg = 0; f_def = 0; f_dat = 0; prev_stall = 0;
        apply_inputs();
        @(negedge clk);
        reset = 1'b0;
        step();
        add_data(3);
        step();
        chk("post_rst_bubble", 64'(tx_val), 64'd0);
        step();
        chk("post_rst_hdr", 64'(tx_dat), 64'h46);
        drain(50);
        compare("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
